// File: rtl/tproc_seq_pkg.sv
// Shared definitions for the convolution tile sequencer: state encoding,
// operation codes and default widths.
package tproc_seq_pkg;

    localparam int TM_DEF        = 16;
    localparam int DRAIN_LAT_DEF = 4;
    localparam int TILE_W_DEF    = 12;
    localparam int CNT_W         = 16;
    localparam int ADDR_W        = 16;

    localparam logic [7:0] COM_CONV   = 8'h01;
    localparam logic [7:0] COM_DWCONV = 8'h02;
    localparam logic [7:0] COM_PWCONV = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CONFIG     = 3'd1,
        ST_SHIFT      = 3'd2,
        ST_WAIT_SHIFT = 3'd3,
        ST_COMPUTE    = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_FINISH     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Control/status bundle between the job host, the vertical register and the
// weight memory. perf_cycles exists only when SEQ_PERF_CNT_EN is defined.
interface conv_tile_sequencer_if #(
    parameter int TILE_W = tproc_seq_pkg::TILE_W_DEF
);
    import tproc_seq_pkg::*;

    // Job control: start is a single-cycle request, only honoured while idle;
    // shift_done is a single-cycle completion pulse, only honoured in WAIT_SHIFT.
    logic              start;
    logic              abort;
    logic [7:0]        com_type;
    logic [TILE_W-1:0] num_tiles;
    logic              shift_done;

    logic              config_enable;
    logic              config_clear;
    logic [7:0]        com_type_o;
    logic              virtical_reg_shift;
    logic              virreg_input_sel;
    logic [ADDR_W-1:0] weight_addr;
    logic              weight_read_en;
    logic              tile_done;
    logic              busy;
    logic              done;
    logic              err;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       perf_cycles;
`endif

    modport master (
`ifdef SEQ_PERF_CNT_EN
        input  perf_cycles,
`endif
        output start, abort, com_type, num_tiles, shift_done,
        input  config_enable, config_clear, com_type_o, virtical_reg_shift,
        input  virreg_input_sel, weight_addr, weight_read_en, tile_done,
        input  busy, done, err
    );

    modport slave (
`ifdef SEQ_PERF_CNT_EN
        output perf_cycles,
`endif
        input  start, abort, com_type, num_tiles, shift_done,
        output config_enable, config_clear, com_type_o, virtical_reg_shift,
        output virreg_input_sel, weight_addr, weight_read_en, tile_done,
        output busy, done, err
    );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down counter used as the COMPUTE and DRAIN window timer; zero
// flags the final cycle of the window.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/conv_tile_sequencer.sv
// Per-job tile sequencer: config, shift, weight sweep and drain per tile.
// Optional busy-cycle counter under SEQ_PERF_CNT_EN.
module conv_tile_sequencer
    import tproc_seq_pkg::*;
#(
    parameter int TM        = TM_DEF,
    parameter int DRAIN_LAT = DRAIN_LAT_DEF,
    parameter int TILE_W    = TILE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_tile_sequencer_if.slave  bus,
    output seq_state_t            state_dbg
);

    seq_state_t        state;
    seq_state_t        state_nx;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_en;
    logic              cnt_zero;
    logic [TILE_W-1:0] tiles_left;
    logic              abort_job;
    logic              tile_end;

    assign abort_job = bus.abort && (state != ST_IDLE);
    assign tile_end  = (state == ST_DRAIN) && cnt_zero;
    assign cnt_en    = (state == ST_COMPUTE) || (state == ST_DRAIN);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.com_type == COM_CONV)) state_nx = ST_CONFIG;
            end
            ST_CONFIG: state_nx = ST_SHIFT;
            ST_SHIFT:  state_nx = ST_WAIT_SHIFT;
            ST_WAIT_SHIFT: begin
                if (bus.shift_done) begin
                    state_nx = ST_COMPUTE;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TM - 1);
                end
            end
            ST_COMPUTE: begin
                if (cnt_zero) begin
                    state_nx = ST_DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DRAIN_LAT - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) state_nx = (tiles_left > TILE_W'(1)) ? ST_SHIFT : ST_FINISH;
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        // Abort overrides every transition, including a pending timer load.
        if (abort_job) begin
            state_nx = ST_IDLE;
            cnt_load = 1'b0;
        end
    end

    seq_down_counter #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Outputs are registered from the next state so each one lines up with
    // the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.config_enable      <= 1'b0;
            bus.config_clear       <= 1'b0;
            bus.com_type_o         <= '0;
            bus.virtical_reg_shift <= 1'b0;
            bus.virreg_input_sel   <= 1'b0;
            bus.weight_addr        <= '0;
            bus.weight_read_en     <= 1'b0;
            bus.tile_done          <= 1'b0;
            bus.busy               <= 1'b0;
            bus.done               <= 1'b0;
            bus.err                <= 1'b0;
            tiles_left             <= '0;
        end else begin
            bus.config_enable      <= (state_nx == ST_CONFIG);
            bus.virtical_reg_shift <= (state_nx == ST_SHIFT);
            bus.weight_read_en     <= (state_nx == ST_COMPUTE);
            bus.busy               <= (state_nx != ST_IDLE);
            bus.done               <= (state_nx == ST_FINISH);
            bus.config_clear       <= (state_nx == ST_FINISH) || abort_job;
            bus.tile_done          <= tile_end && !abort_job;
            bus.err                <= (state == ST_IDLE) && bus.start && (bus.com_type != COM_CONV);

            if (state_nx == ST_COMPUTE) begin
                bus.weight_addr <= (state == ST_COMPUTE) ? bus.weight_addr + ADDR_W'(1) : '0;
            end else begin
                bus.weight_addr <= '0;
            end

            if ((state == ST_IDLE) && (state_nx == ST_CONFIG)) begin
                bus.com_type_o <= bus.com_type;
                tiles_left     <= (bus.num_tiles == '0) ? TILE_W'(1) : bus.num_tiles;
            end else if (tile_end && (state_nx == ST_SHIFT)) begin
                tiles_left <= tiles_left - TILE_W'(1);
            end

            // Ping-pong select flips between tiles and restarts at 0 each job.
            if (tile_end && (state_nx == ST_SHIFT)) begin
                bus.virreg_input_sel <= ~bus.virreg_input_sel;
            end else if ((state_nx == ST_CONFIG) || (state_nx == ST_IDLE)) begin
                bus.virreg_input_sel <= 1'b0;
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_cycles <= '0;
        end else if ((state == ST_IDLE) && (state_nx == ST_CONFIG)) begin
            bus.perf_cycles <= '0;
        end else if (bus.busy) begin
            bus.perf_cycles <= bus.perf_cycles + 32'd1;
        end
    end
`else
    // No busy-cycle history is kept in this build.
`endif

endmodule

// File: doc/conv_tile_sequencer.md
CONV_TILE_SEQUENCER -- requirements
Module: conv_tile_sequencer

Interface
REQ-001 Parameter TM, default 16: output channels per tile; also the weight-address sweep length.
REQ-002 Parameter DRAIN_LAT, default 4: cycles from the last weight read until the datapath result is settled.
REQ-003 Parameter TILE_W, default 12: width of the tile-count input and of the internal tile counter.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  one-cycle job-start request; honoured only in IDLE.
REQ-007 abort  in  1  cancels the job from any state.
REQ-008 com_type  in  8  operation code: 0x01 CONV, 0x02 DWCONV, 0x04 PWCONV.
REQ-009 num_tiles  in  TILE_W  tiles in the job; value 0 is treated as 1.
REQ-010 shift_done  in  1  one-cycle pulse from the vertical register when a shift completes.
REQ-011 config_enable  out  1  loads com_type into the datapath.
REQ-012 config_clear  out  1  clears the datapath com_type register.
REQ-013 com_type_o  out  8  latched com_type.
REQ-014 virtical_reg_shift  out  1  one-cycle shift-start pulse.
REQ-015 virreg_input_sel  out  1  feature-memory ping-pong select.
REQ-016 weight_addr  out  16  weight memory address.
REQ-017 weight_read_en  out  1  weight read strobe.
REQ-018 tile_done  out  1  one-cycle pulse at the end of each tile.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at job end.
REQ-021 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-022 FSM states: IDLE, CONFIG, SHIFT, WAIT_SHIFT, COMPUTE, DRAIN, FINISH.
- IDLE to CONFIG on start with com_type=0x01; latch com_type and num_tiles at that edge.
REQ-023 start with any other com_type: err pulses the next cycle; FSM stays in IDLE.
REQ-024 CONFIG lasts exactly one cycle with config_enable=1, then goes to SHIFT.
REQ-025 SHIFT lasts exactly one cycle with virtical_reg_shift=1, then goes to WAIT_SHIFT.
REQ-026 WAIT_SHIFT holds until shift_done=1, then goes to COMPUTE.
- A shift_done pulse seen in any other state is ignored.
REQ-027 COMPUTE lasts exactly TM cycles.
- weight_read_en=1 throughout.
- weight_addr = 0,1,...,TM-1 on consecutive cycles.
REQ-028 DRAIN lasts exactly DRAIN_LAT cycles with weight_read_en=0.
- On its last cycle the FSM registers a one-cycle tile_done pulse.
REQ-029 After DRAIN with tiles remaining: toggle virreg_input_sel and return to SHIFT.
- Otherwise go to FINISH.
REQ-030 FINISH lasts one cycle with done=1 and config_clear=1, then returns to IDLE.
REQ-031 abort in any non-IDLE state: next cycle is IDLE with config_clear=1 for one cycle.
- No done or tile_done is issued for the aborted job.
- abort has priority over every other transition.
REQ-032 start while busy is ignored and does not raise err.
REQ-033 virreg_input_sel is 0 at the first tile of every job.
REQ-034 The tile counter wraps never: a job of 2^TILE_W-1 tiles completes normally.
REQ-035 All outputs are registered.

Reset
REQ-036 On rst, all outputs are 0, the FSM is in IDLE, and all counters are 0.
REQ-037 rst mid-job behaves as abort except that config_clear stays 0.

Configuration
REQ-038 Macro SEQ_PERF_CNT_EN.
- Defined: adds output perf_cycles (32 bits), counting cycles with busy=1 in the current job, cleared on CONFIG entry, held after FINISH.
- Undefined: the port and its counter are absent.

Structure
REQ-039 The FSM state encoding, the com_type codes (0x01/0x02/0x04), and the default widths live in the shared package tproc_seq_pkg.
REQ-040 One sub-module, seq_down_counter, is instantiated for both the COMPUTE and DRAIN timers.

Verification
REQ-041 CONV job, TM=16, DRAIN_LAT=4, num_tiles=1, shift_done 3 cycles after the shift pulse.
- Addresses 0..15 on 16 consecutive cycles.
- tile_done is issued after the DRAIN window, followed by one done pulse and config_clear.
REQ-042 num_tiles=3.
- Exactly 3 tile_done pulses and 3 shift pulses.
- virreg_input_sel sequence 0,1,0.
- One done pulse.
REQ-043 start with com_type=0x02 -> err pulses once, busy stays 0, no config_enable.
REQ-044 abort on weight_addr=7 -> next cycle busy=0, config_clear=1, weight_read_en=0, and done never pulses.
REQ-045 num_tiles=0 -> behaves exactly as num_tiles=1.
REQ-046 rst asserted in WAIT_SHIFT -> all outputs 0; a later start runs a full job normally.
